// File: rtl/muldiv_unit_pkg.sv
// Shared CPU package: ALU control and mul/div encodings.
// Latencies of the HI/LO unit live here too.
package muldiv_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_LUI
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic {
    IDLE,
    RUN
  } md_state_e;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_FIX = 33;
  localparam int CNT_W       = 6;

  function automatic logic is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic is_signed(input op_e op);
    return !op[0];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the pipeline and
// the HI/LO unit.
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic        start;
  op_e         op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b,
    output mthi, mtlo, cancel,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    input  mthi, mtlo, cancel,
    output busy, hi, lo
  );

endinterface

// File: rtl/muldiv_unit_div_iter.sv
// Restoring divider datapath on unsigned magnitudes.
// Exposes the post-step values so the last step can be written directly.
module div_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quo_next,
  output logic [31:0] rem_next
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [32:0] shifted;
  logic        ge;

  // One restoring step: shift in next dividend bit, subtract if it fits
  always_comb begin
    shifted  = {rem_q, quo_q[31]};
    ge       = shifted >= {1'b0, divisor};
    rem_next = ge ? 32'(shifted - {1'b0, divisor})
                  : shifted[31:0];
    quo_next = {quo_q[30:0], ge};
  end

  // Remainder/quotient shift registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
    end else if (init) begin
      rem_q <= '0;
      quo_q <= dividend;
    end else if (step) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit with IDLE/RUN control.
// Multiply is computed at the write edge; divide iterates in div_iter.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);

  localparam int DIV_LAT = DIV_LAT_FIX;
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  op_e              op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic             busy_q;

  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [31:0] quo_next;
  logic [31:0] rem_next;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_run;
  logic        div_init;
  logic        div_step;

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  assign div_run  = (state == RUN) && is_div(op_q);
  assign div_init = div_run && (cnt == DIV_LD);
  assign div_step = div_run && (cnt < DIV_LD);

  div_iter u_div_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (div_init),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  // Operand magnitudes, product and sign-fixed final result
  always_comb begin
    sgn   = is_signed(op_q);
    a_neg = sgn & a_q[31];
    b_neg = sgn & b_q[31];
    a_mag = a_neg ? -a_q : a_q;
    b_mag = b_neg ? -b_q : b_q;
    ext_a = {{32{a_neg}}, a_q};
    ext_b = {{32{b_neg}}, b_q};
    prod  = ext_a * ext_b;
    if (!is_div(op_q)) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (b_q == '0) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_hi = a_neg ? -rem_next : rem_next;
      res_lo = (a_neg ^ b_neg) ? -quo_next : quo_next;
    end
  end

  // Control FSM with registered busy and HI/LO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      op_q   <= OP_MULT;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.mthi) hi_q <= bus.a;
          if (bus.mtlo) lo_q <= bus.a;
          if (bus.start) begin
            op_q   <= bus.op;
            a_q    <= bus.a;
            b_q    <= bus.b;
            cnt    <= is_div(bus.op) ? DIV_LD : MUL_LD;
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.cancel) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (cnt == '0) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a result scoreboard.
// Expected HI/LO come from a behavioural model of each op.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [63:0] sb[$];

  muldiv_unit_if m ();

  muldiv_unit #(.MUL_LAT(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(
    input logic [1:0] op, input logic [31:0] a,
    input logic [31:0] b);
    longint sp;
    int sa, sb2;
    sa  = a;
    sb2 = b;
    case (op)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      2'b01: return 64'(a) * 64'(b);
      2'b10: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          return {32'h0, 32'h80000000};
        return {32'(sa % sb2), 32'(sa / sb2)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic launch(string tag, op_e op,
                        logic [31:0] a, logic [31:0] b);
    sb.push_back(model(op, a, b));
    m.start = 1'b1;
    m.op    = op;
    m.a     = a;
    m.b     = b;
    tick();
    m.start = 1'b0;
    chk({tag, "_busy"}, 64'(m.busy), 64'd1);
  endtask

  task automatic wait_done(string tag, int lat);
    int edges;
    logic [63:0] exp;
    edges = 0;
    while (m.busy && edges < 100) begin
      tick();
      edges++;
    end
    chk({tag, "_lat"}, 64'(edges), 64'(lat));
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
    chk({tag, "_res"}, {m.hi, m.lo}, exp);
  endtask

  initial begin
    logic [31:0] hsave;
    logic [31:0] lsave;
    logic [31:0] ta[6];
    logic [31:0] tb[6];
    op_e         to[6];

    rst_n    = 1'b0;
    m.start  = 1'b1;
    m.op     = OP_MULTU;
    m.a      = 32'hDEADBEEF;
    m.b      = 32'h3;
    m.mthi   = 1'b1;
    m.mtlo   = 1'b1;
    m.cancel = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(m.busy), 64'd0);
    chk("rst_hilo", {m.hi, m.lo}, 64'd0);
    m.start = 1'b0;
    m.mthi  = 1'b0;
    m.mtlo  = 1'b0;
    rst_n   = 1'b1;
    tick();
    chk("idle_busy", 64'(m.busy), 64'd0);

    launch("mult", OP_MULT, 32'hFFFFFFFE, 32'd3);
    wait_done("mult", 5);
    chk("mult_const", {m.hi, m.lo},
        64'hFFFFFFFF_FFFFFFFA);

    launch("b2b_multu", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("b2b_multu", 5);
    chk("multu_const", {m.hi, m.lo},
        64'hFFFFFFFE_00000001);

    launch("div", OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done("div", 33);
    chk("div_const", {m.hi, m.lo},
        64'hFFFFFFFF_FFFFFFFD);

    launch("divu0", OP_DIVU, 32'd7, 32'd0);
    wait_done("divu0", 33);
    chk("divu0_const", {m.hi, m.lo},
        64'h00000007_FFFFFFFF);

    ta = '{32'h80000000, 32'd7, 32'hFFFFFF85, 32'd1000,
           32'hCAFEBABE, 32'h12345678};
    tb = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0, 32'd7,
           32'h00010001, 32'hFFFF0000};
    to = '{OP_DIV, OP_DIV, OP_DIV, OP_DIVU, OP_DIVU, OP_MULT};
    for (int i = 0; i < 6; i++) begin
      launch($sformatf("tbl%0d", i), to[i], ta[i], tb[i]);
      wait_done($sformatf("tbl%0d", i),
                is_div(to[i]) ? 33 : 5);
    end
    launch("rnd", OP_MULTU, $urandom, $urandom);
    wait_done("rnd", 5);

    m.a    = 32'h12345678;
    m.mthi = 1'b1;
    tick();
    m.a    = 32'h9ABCDEF0;
    m.mthi = 1'b0;
    m.mtlo = 1'b1;
    tick();
    m.mtlo = 1'b0;
    chk("mthi_mtlo", {m.hi, m.lo},
        64'h12345678_9ABCDEF0);
    m.a    = 32'h0BADF00D;
    m.mthi = 1'b1;
    m.mtlo = 1'b1;
    tick();
    m.mthi = 1'b0;
    m.mtlo = 1'b0;
    chk("mt_both", {m.hi, m.lo},
        64'h0BADF00D_0BADF00D);

    m.cancel = 1'b1;
    tick();
    m.cancel = 1'b0;
    chk("cancel_idle", {31'd0, m.busy, m.hi},
        {31'd0, 1'b0, 32'h0BADF00D});

    hsave = m.hi;
    lsave = m.lo;
    m.start = 1'b1;
    m.op    = OP_DIVU;
    m.a     = 32'd100;
    m.b     = 32'd9;
    tick();
    m.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    m.start = 1'b1;
    m.op    = OP_MULT;
    m.mthi  = 1'b1;
    m.a     = 32'h55555555;
    tick();
    m.start = 1'b0;
    m.mthi  = 1'b0;
    chk("run_mthi", 64'(m.hi), 64'(hsave));
    for (int i = 0; i < 4; i++) tick();
    chk("pre_cancel_busy", 64'(m.busy), 64'd1);
    m.cancel = 1'b1;
    tick();
    m.cancel = 1'b0;
    chk("cancel_busy", 64'(m.busy), 64'd0);
    chk("cancel_hilo", {m.hi, m.lo}, {hsave, lsave});
    for (int i = 0; i < 40; i++) tick();
    chk("cancel_late", {31'd0, m.busy, m.hi, m.lo},
        {31'd0, 1'b0, hsave, lsave});

    m.mthi = 1'b1;
    launch("mt_start", OP_MULTU, 32'h00000010, 32'h00000020);
    m.mthi = 1'b0;
    chk("mt_start_hi", 64'(m.hi), 64'h10);
    wait_done("mt_start", 5);

    launch("rst_mid", OP_MULT, 32'hFFFFFFFF, 32'h7);
    void'(sb.pop_back());
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_busy", 64'(m.busy), 64'd0);
    chk("rst_mid_hilo", {m.hi, m.lo}, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("rst_no_late", {31'd0, m.busy, m.hi, m.lo}, 64'd0);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    launch("post_rst", OP_DIV, 32'd100, 32'hFFFFFFF9);
    wait_done("post_rst", 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
